id_stage: RTL and testbench

//   Instruction-decode stage of the 5-stage 16-bit pipeline. Sits directly downstream of the

---
 rtl/id_stage_if.sv | 38 +++
 rtl/id_stage.sv | 124 ++++++++++++
 tb/tb_id_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if
//   Pipeline bus around the instruction-decode stage. It carries:
//   - the fetched instruction (id_ir);
//   - the EX/MEM/WB forwarding and write-back buses;
//   - the registered outputs handed to the EX stage.
//   Modports:
//     master : surrounding pipeline (drives instruction/forwarding, reads outputs)
//     slave  : id_stage itself
// ---------------------------------------------------------------------------
interface id_stage_if;
    logic [15:0] id_ir;
    logic        ex_we;
    logic [2:0]  ex_dst;
    logic [15:0] ex_result;
    logic        mem_we;
    logic [2:0]  mem_dst;
    logic [15:0] mem_result;
    logic        wb_we;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic [15:0] ex_ir;
    logic [15:0] reg_A;
    logic [15:0] reg_B;
    logic [15:0] smdr;

    modport master (
        output id_ir, ex_we, ex_dst, ex_result, mem_we, mem_dst, mem_result,
               wb_we, wb_dst, wb_data,
        input  ex_ir, reg_A, reg_B, smdr
    );

    modport slave (
        input  id_ir, ex_we, ex_dst, ex_result, mem_we, mem_dst, mem_result,
               wb_we, wb_dst, wb_data,
        output ex_ir, reg_A, reg_B, smdr
    );
endinterface

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage of the 5-stage 16-bit pipeline.
//   - Holds the 8x16 general register file.
//   - Reads operands with forwarding priority EX > MEM > WB > file.
//   - Registers ex_ir/reg_A/reg_B/smdr for the EX stage.
//   The stage never stalls: the fetch stage already inserts the LOAD-use bubble.
//
//   Ports:
//     clock  : pipeline clock, rising edge
//     reset  : asynchronous, active-low; clears outputs and register file
//     state  : CPU run state; everything advances only when state == EXEC
//     jump   : taken branch downstream; squashes this stage into a NOP bubble
//     bus    : id_stage_if.slave (instruction, forwarding, write-back, outputs)
// ---------------------------------------------------------------------------
module id_stage (
    input  logic          clock,
    input  logic          reset,
    input  logic          state,
    input  logic          jump,
    id_stage_if.slave     bus
);
    localparam int   NREG = 8;
    localparam logic EXEC = 1'b1;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011,
        OP_SLL  = 5'b00100, OP_SLA  = 5'b00101, OP_SRL  = 5'b00110, OP_SRA   = 5'b00111,
        OP_ADD  = 5'b01000, OP_ADDI = 5'b01001, OP_SUB  = 5'b01010, OP_SUBI  = 5'b01011,
        OP_CMP  = 5'b01100, OP_AND  = 5'b01101, OP_OR   = 5'b01110, OP_XOR   = 5'b01111,
        OP_LDIH = 5'b10000, OP_ADDC = 5'b10001, OP_SUBC = 5'b10010,
        OP_JUMP = 5'b11000, OP_JMPR = 5'b11001, OP_BZ   = 5'b11010, OP_BNZ   = 5'b11011,
        OP_BN   = 5'b11100, OP_BNN  = 5'b11101, OP_BC   = 5'b11110, OP_BNC   = 5'b11111
    } opcode_e;

    logic [15:0] gr [NREG];

    opcode_e     op;
    logic [2:0]  sel [3];          // register specifiers r1, r2, r3
    logic [15:0] rdv [3];          // forwarded operand value per specifier
    logic [15:0] next_a;
    logic [15:0] next_b;
    logic [15:0] next_smdr;

    assign op     = opcode_e'(bus.id_ir[15:11]);
    assign sel[0] = bus.id_ir[10:8];
    assign sel[1] = bus.id_ir[6:4];
    assign sel[2] = bus.id_ir[2:0];

    // Youngest producer wins: an in-flight EX result is newer than MEM, which is newer
    // than the value being written back this cycle, which is newer than the file.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (bus.ex_we && bus.ex_dst == sel[i])
                rdv[i] = bus.ex_result;
            else if (bus.mem_we && bus.mem_dst == sel[i])
                rdv[i] = bus.mem_result;
            else if (bus.wb_we && bus.wb_dst == sel[i])
                rdv[i] = bus.wb_data;
            else
                rdv[i] = gr[sel[i]];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_a    = '0;
        next_b    = '0;
        next_smdr = '0;
        unique case (op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
                next_a = rdv[1];
                next_b = rdv[2];
            end
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_LOAD: begin
                next_a = rdv[1];
                next_b = {12'b0, bus.id_ir[3:0]};
            end
            OP_STORE: begin
                next_a    = rdv[1];
                next_b    = {12'b0, bus.id_ir[3:0]};
                next_smdr = rdv[0];
            end
            OP_ADDI, OP_SUBI, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR: begin
                next_a = rdv[0];
                next_b = {8'b0, bus.id_ir[7:0]};
            end
            OP_LDIH: begin
                next_a = rdv[0];
                next_b = {bus.id_ir[7:0], 8'b0};
            end
            OP_JUMP: begin
                next_b = {8'b0, bus.id_ir[7:0]};
            end
            default: ;  // NOP, HALT: both operands zero
        endcase
    end

    // NOTE: the register file is a small flop array, so it is cleared on reset like any
    // other state; sequential state is only ever assigned with non-blocking <=.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) gr[i] <= '0;
            bus.ex_ir <= '0;
            bus.reg_A <= '0;
            bus.reg_B <= '0;
            bus.smdr  <= '0;
        end else if (state == EXEC) begin
            if (bus.wb_we) gr[bus.wb_dst] <= bus.wb_data;
            if (jump) begin
                // Squash into a NOP bubble; the write-back above still lands.
                bus.ex_ir <= '0;
                bus.reg_A <= '0;
                bus.reg_B <= '0;
                bus.smdr  <= '0;
            end else begin
                bus.ex_ir <= bus.id_ir;
                bus.reg_A <= next_a;
                bus.reg_B <= next_b;
                bus.smdr  <= next_smdr;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
//   Directed bench for id_stage: reset, register file write/read, forwarding
//   priority, operand selection per instruction class, flush and hold.
// ---------------------------------------------------------------------------
module tb_id_stage;
    logic clock;
    logic reset;
    logic state;
    logic jump;

    int checks   = 0;
    int failures = 0;

    // Hand-assembled instructions
    localparam logic [15:0] I_ADD   = 16'h4123;  // ADD   r1,r2,r3
    localparam logic [15:0] I_STORE = 16'h1D64;  // STORE r5,r6,4
    localparam logic [15:0] I_LDIH  = 16'h81AB;  // LDIH  r1,0xAB
    localparam logic [15:0] I_SLL   = 16'h2123;  // SLL   r1,r2,3
    localparam logic [15:0] I_ADDI  = 16'h4910;  // ADDI  r1,0x10
    localparam logic [15:0] I_JUMP  = 16'hC122;  // JUMP  0x22
    localparam logic [15:0] I_BZ    = 16'hD105;  // BZ    r1,0x05
    localparam logic [15:0] I_HALT  = 16'h0800;  // HALT

    id_stage_if bus ();

    id_stage dut (
        .clock (clock),
        .reset (reset),
        .state (state),
        .jump  (jump),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] dst, input logic [15:0] data);
        bus.wb_we   = 1'b1;
        bus.wb_dst  = dst;
        bus.wb_data = data;
        step();
        bus.wb_we   = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [15:0] ir, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] s);
        check({tag, ".ex_ir"}, bus.ex_ir, ir);
        check({tag, ".reg_A"}, bus.reg_A, a);
        check({tag, ".reg_B"}, bus.reg_B, b);
        check({tag, ".smdr"},  bus.smdr,  s);
    endtask

    initial begin
        reset = 1'b0;  state = 1'b1;  jump = 1'b0;
        bus.id_ir = '0;
        bus.ex_we = 0;  bus.ex_dst = '0;  bus.ex_result = '0;
        bus.mem_we = 0; bus.mem_dst = '0; bus.mem_result = '0;
        bus.wb_we = 0;  bus.wb_dst = '0;  bus.wb_data = '0;
        step();
        check_out("por", 16'h0, 16'h0, 16'h0, 16'h0);
        reset = 1'b1;

        // 1: reset mid-run clears outputs and file without a clock edge
        wb_write(3'd2, 16'h1111);
        wb_write(3'd3, 16'h2222);
        bus.id_ir = I_ADD;
        step();
        check_out("pre_rst", I_ADD, 16'h1111, 16'h2222, 16'h0);
        #3 reset = 1'b0;
        #1 check_out("async_rst", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clock) reset = 1'b1;
        step();
        check_out("post_rst_add", I_ADD, 16'h0, 16'h0, 16'h0);

        // 2: register file write then read
        bus.id_ir = '0;
        wb_write(3'd2, 16'h1234);
        wb_write(3'd3, 16'h00FF);
        bus.id_ir = I_ADD;
        step();
        check_out("add_file", I_ADD, 16'h1234, 16'h00FF, 16'h0);

        // 3: forwarding priority EX > MEM > WB
        bus.ex_we  = 1; bus.ex_dst  = 3'd2; bus.ex_result  = 16'hAAAA;
        bus.mem_we = 1; bus.mem_dst = 3'd2; bus.mem_result = 16'hBBBB;
        bus.wb_we  = 1; bus.wb_dst  = 3'd2; bus.wb_data    = 16'hCCCC;
        step();
        check("fwd_ex", bus.reg_A, 16'hAAAA);
        check("fwd_ex_B", bus.reg_B, 16'h00FF);
        bus.ex_we = 0;
        step();
        check("fwd_mem", bus.reg_A, 16'hBBBB);
        bus.mem_we = 0;
        step();
        check("fwd_wb", bus.reg_A, 16'hCCCC);
        bus.wb_we = 0;
        step();
        check("file_gr2", bus.reg_A, 16'hCCCC);

        // 4: STORE / LDIH / SLL operand selection
        bus.id_ir = '0;
        wb_write(3'd5, 16'h5555);
        wb_write(3'd6, 16'h0040);
        bus.id_ir = I_STORE;
        step();
        check_out("store", I_STORE, 16'h0040, 16'h0004, 16'h5555);
        bus.id_ir = I_LDIH;
        step();
        check_out("ldih", I_LDIH, 16'h0000, 16'hAB00, 16'h0);
        bus.id_ir = I_SLL;
        step();
        check_out("sll", I_SLL, 16'hCCCC, 16'h0003, 16'h0);

        // 5: jump flush, file write in the same cycle still lands
        bus.id_ir = I_ADDI;
        jump = 1'b1;
        bus.wb_we = 1; bus.wb_dst = 3'd1; bus.wb_data = 16'h0777;
        step();
        check_out("flush", 16'h0, 16'h0, 16'h0, 16'h0);
        jump = 1'b0;
        bus.wb_we = 0;
        step();
        check_out("addi", I_ADDI, 16'h0777, 16'h0010, 16'h0);

        // 6: hold when not executing; writes suppressed
        state = 1'b0;
        bus.id_ir = I_STORE;
        bus.wb_we = 1; bus.wb_dst = 3'd1; bus.wb_data = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("hold%0d", i), I_ADDI, 16'h0777, 16'h0010, 16'h0);
        end
        state = 1'b1;
        bus.wb_we = 0;
        bus.id_ir = I_ADDI;
        step();
        check_out("resume", I_ADDI, 16'h0777, 16'h0010, 16'h0);

        // Remaining classes: JUMP, branch, HALT
        bus.id_ir = I_JUMP;
        step();
        check_out("jump_op", I_JUMP, 16'h0, 16'h0022, 16'h0);
        bus.id_ir = I_BZ;
        step();
        check_out("bz", I_BZ, 16'h0777, 16'h0005, 16'h0);
        bus.id_ir = I_HALT;
        step();
        check_out("halt", I_HALT, 16'h0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
